// File: rtl/exec_unit_16bit_if.sv
// exec_unit_16bit_if: request/result bundle between a register bank and the
// execution unit. The bank (or a bench) is the master: it raises start with
// an opcode, operands and destination. The execution unit is the slave: it
// returns busy, the write strobe with address/data, done and the status flags.
interface exec_unit_16bit_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);

  logic              start;
  logic [2:0]        op;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic [ADDR_W-1:0] dest;

  logic              busy;
  logic              write;
  logic [ADDR_W-1:0] write_addr;
  logic [WIDTH-1:0]  write_data;
  logic              done;
  logic              flag_z;
  logic              flag_n;
  logic              flag_c;
  logic              flag_v;

  modport master (
    output start, op, opa, opb, dest,
    input  busy, write, write_addr, write_data, done,
    input  flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  start, op, opa, opb, dest,
    output busy, write, write_addr, write_data, done,
    output flag_z, flag_n, flag_c, flag_v
  );

endinterface

// File: rtl/exec_unit_16bit.sv
// exec_unit_16bit: multi-cycle execution unit.
// Single-cycle ALU ops take one EXEC cycle. MUL is an unsigned shift-add over
// WIDTH cycles. Every op then finishes with one WB cycle that strobes write
// and done. The result, destination and flags are registered on the edge
// into WB and hold there until the next WB, so consumers qualify them with write.
module exec_unit_16bit #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input logic              clk,
  input logic              reset_n,
  exec_unit_16bit_if.slave bus
);

  // Shift amounts and the multiply bit counter both span one operand width.
  localparam int              SH_W     = $clog2(WIDTH);
  localparam logic [SH_W-1:0] LAST_CNT = SH_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  // Control state.
  state_t r_state;
  state_t w_stateNext;

  // Operands captured at the accepting edge.
  op_t               r_op;
  logic [WIDTH-1:0]  r_opa;
  logic [WIDTH-1:0]  r_opb;
  logic [ADDR_W-1:0] r_dest;

  // Shift-add multiplier state.
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [SH_W-1:0]    r_cnt;

  // Registered results presented to the register bank.
  logic [WIDTH-1:0]  r_writeData;
  logic [ADDR_W-1:0] r_writeAddr;
  logic              r_flagZ;
  logic              r_flagN;
  logic              r_flagC;
  logic              r_flagV;

  // Combinational helpers.
  logic               w_accept;
  logic               w_mulLast;
  logic               w_commit;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [SH_W-1:0]    w_shamt;
  logic [WIDTH-1:0]   w_aluResult;
  logic               w_aluC;
  logic               w_aluV;
  logic [2*WIDTH-1:0] w_mulSum;
  logic [WIDTH-1:0]   w_result;
  logic               w_resC;
  logic               w_resV;

  // A request is only taken in IDLE, so a start seen while busy is dropped
  // with no queuing.
  assign w_accept  = (r_state == S_IDLE) && bus.start;
  assign w_mulLast = (r_state == S_MUL) && (r_cnt == LAST_CNT);
  // The edge leaving EXEC, or the one leaving the last MUL cycle, is the
  // edge entering WB. That is where the result and flags are registered.
  assign w_commit  = (r_state == S_EXEC) || w_mulLast;

  // State register; an asserted reset_n abandons any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: IDLE dispatches on opcode, EXEC lasts one cycle, MUL runs
  // until the last multiplier bit, and WB lasts one cycle.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_stateNext = (bus.op == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: w_stateNext = S_WB;
      S_MUL: begin
        if (r_cnt == LAST_CNT) begin
          w_stateNext = S_WB;
        end
      end
      S_WB:    w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Capture the request on accept and keep it untouched until the next accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op   <= OP_ADD;
      r_opa  <= '0;
      r_opb  <= '0;
      r_dest <= '0;
    end else if (w_accept) begin
      r_op   <= op_t'(bus.op);
      r_opa  <= bus.opa;
      r_opb  <= bus.opb;
      r_dest <= bus.dest;
    end
  end

  // Shift-add multiplier. Each MUL cycle consumes one multiplier bit, LSB
  // first, and adds the shifted multiplicand into the accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, bus.opa};
      r_mplier <= bus.opb;
      r_cnt    <= '0;
    end else if (r_state == S_MUL) begin
      r_acc    <= w_mulSum;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt + SH_W'(1);
    end
  end

  // This cycle's partial product. On the last MUL cycle it is the full product.
  assign w_mulSum = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Single-cycle ALU. The extra top bit of the add/sub/shift vectors holds
  // the carry/borrow. For SHR an extra bottom bit catches the last bit
  // shifted out. A zero shift amount leaves both guard bits at zero.
  always_comb begin
    w_add       = {1'b0, r_opa} + {1'b0, r_opb};
    w_sub       = {1'b0, r_opa} - {1'b0, r_opb};
    w_shamt     = r_opb[SH_W-1:0];
    w_shl       = {1'b0, r_opa} << w_shamt;
    w_shr       = {r_opa, 1'b0} >> w_shamt;
    w_aluResult = '0;
    w_aluC      = 1'b0;
    w_aluV      = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_aluResult = w_add[WIDTH-1:0];
        w_aluC      = w_add[WIDTH];
        w_aluV      = (r_opa[WIDTH-1] == r_opb[WIDTH-1]) &&
                      (w_add[WIDTH-1] != r_opa[WIDTH-1]);
      end
      OP_SUB: begin
        w_aluResult = w_sub[WIDTH-1:0];
        w_aluC      = w_sub[WIDTH];
        w_aluV      = (r_opa[WIDTH-1] != r_opb[WIDTH-1]) &&
                      (w_sub[WIDTH-1] != r_opa[WIDTH-1]);
      end
      OP_AND: w_aluResult = r_opa & r_opb;
      OP_OR:  w_aluResult = r_opa | r_opb;
      OP_XOR: w_aluResult = r_opa ^ r_opb;
      OP_SHL: begin
        w_aluResult = w_shl[WIDTH-1:0];
        w_aluC      = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_aluResult = w_shr[WIDTH:1];
        w_aluC      = w_shr[0];
      end
      default: begin
        w_aluResult = '0;
        w_aluC      = 1'b0;
        w_aluV      = 1'b0;
      end
    endcase
  end

  // MUL reports the low half of the product. Its carry flags a non-zero
  // upper half.
  assign w_result = (r_state == S_MUL) ? w_mulSum[WIDTH-1:0] : w_aluResult;
  assign w_resC   = (r_state == S_MUL) ? (|w_mulSum[2*WIDTH-1:WIDTH]) : w_aluC;
  assign w_resV   = (r_state == S_MUL) ? 1'b0 : w_aluV;

  // Result, destination and flags load only on the edge into WB and hold
  // until the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_writeData <= '0;
      r_writeAddr <= '0;
      r_flagZ     <= 1'b0;
      r_flagN     <= 1'b0;
      r_flagC     <= 1'b0;
      r_flagV     <= 1'b0;
    end else if (w_commit) begin
      r_writeData <= w_result;
      r_writeAddr <= r_dest;
      r_flagZ     <= (w_result == '0);
      r_flagN     <= w_result[WIDTH-1];
      r_flagC     <= w_resC;
      r_flagV     <= w_resV;
    end
  end

  // Status outputs decode straight from the registered state, so write and
  // done are a clean single-cycle pulse in WB.
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.write      = (r_state == S_WB);
  assign bus.done       = (r_state == S_WB);
  assign bus.write_addr = r_writeAddr;
  assign bus.write_data = r_writeData;
  assign bus.flag_z     = r_flagZ;
  assign bus.flag_n     = r_flagN;
  assign bus.flag_c     = r_flagC;
  assign bus.flag_v     = r_flagV;

endmodule

// File: tb/tb_exec_unit_16bit.sv
// tb_exec_unit_16bit: directed bench for exec_unit_16bit. A latency/arithmetic
// reference model predicts every output each cycle. Table vectors carry
// hand-computed results, flags and latencies.
module tb_exec_unit_16bit;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic clk;
  logic reset_n;

  int nAsserts = 0;
  int nFails   = 0;

  exec_unit_16bit_if #(.WIDTH(16), .ADDR_W(3)) bus ();

  exec_unit_16bit #(.WIDTH(16), .ADDR_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison goes through here so the counters stay in one place.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAsserts++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Arithmetic reference in plain integer math. Returns {z,n,c,v, result[15:0]}.
  function automatic logic [19:0] modelOp(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    longint ua;
    longint ub;
    longint r;
    int     sa;
    int     sb;
    int     s;
    int     amt;
    logic   c;
    logic   v;
    logic [15:0] res;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    amt = int'(b) % 16;
    r   = 0;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      OP_ADD: begin
        r = ua + ub; c = (r > 65535); s = sa + sb; v = (s > 32767) || (s < -32768);
      end
      OP_SUB: begin
        r = ua - ub; c = (ua < ub); s = sa - sb; v = (s > 32767) || (s < -32768);
      end
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      OP_XOR: r = ua ^ ub;
      OP_SHL: begin
        r = ua << amt; c = (amt != 0) && (((ua >> (16 - amt)) & 1) == 1);
      end
      OP_SHR: begin
        r = ua >> amt; c = (amt != 0) && (((ua >> (amt - 1)) & 1) == 1);
      end
      default: begin
        r = ua * ub; c = ((r >> 16) != 0);
      end
    endcase
    res = r[15:0];
    return {(res == 16'h0000), res[15], c, v, res};
  endfunction

  // Timing model: an accepted op keeps the unit busy for 2 cycles (or 17 for
  // MUL). The last busy cycle is the write cycle, and the outputs take the
  // new result on the edge that enters it.
  int          mBusyLeft = 0;
  logic [19:0] mPend     = '0;
  logic [2:0]  mPendAddr = '0;
  logic [15:0] mData     = '0;
  logic [2:0]  mAddr     = '0;
  logic [3:0]  mFlags    = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mBusyLeft <= 0;
      mData     <= '0;
      mAddr     <= '0;
      mFlags    <= '0;
    end else if (mBusyLeft == 0) begin
      if (bus.start) begin
        mPend     <= modelOp(bus.op, bus.opa, bus.opb);
        mPendAddr <= bus.dest;
        mBusyLeft <= (bus.op == OP_MUL) ? 17 : 2;
      end
    end else begin
      mBusyLeft <= mBusyLeft - 1;
      if (mBusyLeft == 2) begin
        mData  <= mPend[15:0];
        mFlags <= mPend[19:16];
        mAddr  <= mPendAddr;
      end
    end
  end

  // Per-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    checkOutput("cyc_busy",  32'(bus.busy),  32'(mBusyLeft > 0));
    checkOutput("cyc_write", 32'(bus.write), 32'(mBusyLeft == 1));
    checkOutput("cyc_done",  32'(bus.done),  32'(mBusyLeft == 1));
    checkOutput("cyc_addr",  32'(bus.write_addr), 32'(mAddr));
    checkOutput("cyc_data",  32'(bus.write_data), 32'(mData));
    checkOutput("cyc_flags", 32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 32'(mFlags));
  end

  // Independent write/done counters with the last written address and data.
  int          writeCount = 0;
  int          doneCount  = 0;
  logic [15:0] lastData   = '0;
  logic [2:0]  lastAddr   = '0;

  always @(negedge clk) begin
    if (bus.write) begin
      writeCount++;
      lastData = bus.write_data;
      lastAddr = bus.write_addr;
    end
    if (bus.done) doneCount++;
  end

  // Issue one request from an IDLE negedge and wait (bounded) for its write
  // cycle. Then step one more cycle so the unit is IDLE again on return.
  task automatic applyStimulus(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                               input logic [2:0] d, output int lat, output int busyCnt,
                               output logic [15:0] data, output logic [2:0] addr, output logic [3:0] flg);
    bus.op    = o;
    bus.opa   = a;
    bus.opb   = b;
    bus.dest  = d;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat     = -1;
    busyCnt = 0;
    data    = '0;
    addr    = '0;
    flg     = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.busy) busyCnt++;
      if (bus.write) begin
        lat  = k;
        data = bus.write_data;
        addr = bus.write_addr;
        flg  = {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
        break;
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  d;
    logic [15:0] eData;
    logic [3:0]  eFlags;
    int          eLat;
  } vec_t;

  vec_t vecs [15];

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    int          busyCnt;
    logic [15:0] data;
    logic [2:0]  addr;
    logic [3:0]  flg;
    int          wc;
    int          dc;

    // Expected flags are ordered {z,n,c,v}.
    vecs[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 3'd3, 16'h8000, 4'b0101, 2};
    vecs[1]  = '{OP_SUB, 16'h0002, 16'h0003, 3'd1, 16'hFFFF, 4'b0110, 2};
    vecs[2]  = '{OP_XOR, 16'hAAAA, 16'hAAAA, 3'd2, 16'h0000, 4'b1000, 2};
    vecs[3]  = '{OP_SUB, 16'h0005, 16'h0005, 3'd4, 16'h0000, 4'b1000, 2};
    vecs[4]  = '{OP_MUL, 16'h0100, 16'h0100, 3'd5, 16'h0000, 4'b1010, 17};
    vecs[5]  = '{OP_MUL, 16'hFFFD, 16'h0003, 3'd6, 16'hFFF7, 4'b0110, 17};
    vecs[6]  = '{OP_SHL, 16'h8001, 16'hFFF1, 3'd7, 16'h0002, 4'b0010, 2};
    vecs[7]  = '{OP_SHR, 16'h1234, 16'h0010, 3'd0, 16'h1234, 4'b0000, 2};
    vecs[8]  = '{OP_SHR, 16'h0003, 16'h0001, 3'd1, 16'h0001, 4'b0010, 2};
    vecs[9]  = '{OP_AND, 16'hF0F0, 16'h0FF0, 3'd2, 16'h00F0, 4'b0000, 2};
    vecs[10] = '{OP_OR,  16'h8000, 16'h0001, 3'd3, 16'h8001, 4'b0100, 2};
    vecs[11] = '{OP_ADD, 16'hFFFF, 16'h0001, 3'd4, 16'h0000, 4'b1010, 2};
    vecs[12] = '{OP_SUB, 16'h8000, 16'h0001, 3'd5, 16'h7FFF, 4'b0001, 2};
    vecs[13] = '{OP_MUL, 16'h00FF, 16'h0101, 3'd6, 16'hFFFF, 4'b0100, 17};
    vecs[14] = '{OP_SHL, 16'h0001, 16'h000F, 3'd7, 16'h8000, 4'b0100, 2};

    bus.start = 1'b0;
    bus.op    = '0;
    bus.opa   = '0;
    bus.opb   = '0;
    bus.dest  = '0;
    reset_n   = 1'b1;
    #1 reset_n = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_busy",  32'(bus.busy),  32'd0);
    checkOutput("rst_write", 32'(bus.write), 32'd0);
    checkOutput("rst_done",  32'(bus.done),  32'd0);
    checkOutput("rst_addr",  32'(bus.write_addr), 32'd0);
    checkOutput("rst_data",  32'(bus.write_data), 32'd0);
    checkOutput("rst_flags", 32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed operation vectors.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, lat, busyCnt, data, addr, flg);
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].eLat));
      checkOutput($sformatf("v%0d_busy_cycles", i), 32'(busyCnt), 32'(vecs[i].eLat));
      checkOutput($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].eData));
      checkOutput($sformatf("v%0d_addr", i), 32'(addr), 32'(vecs[i].d));
      checkOutput($sformatf("v%0d_flags", i), 32'(flg), 32'(vecs[i].eFlags));
    end

    // Reset dropped in MUL cycle 8: the unit goes idle at once with no write.
    bus.op    = OP_MUL;
    bus.opa   = 16'h0100;
    bus.opb   = 16'h0100;
    bus.dest  = 3'd6;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 2; k <= 8; k++) @(posedge clk);
    wc = writeCount;
    #3 reset_n = 1'b0;
    #1;
    checkOutput("midrst_busy",  32'(bus.busy),  32'd0);
    checkOutput("midrst_write", 32'(bus.write), 32'd0);
    checkOutput("midrst_data",  32'(bus.write_data), 32'd0);
    checkOutput("midrst_flags", 32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("midrst_no_write", 32'(writeCount), 32'(wc));
    reset_n = 1'b1;
    applyStimulus(OP_ADD, 16'h0001, 16'h0002, 3'd2, lat, busyCnt, data, addr, flg);
    checkOutput("postrst_latency", 32'(lat), 32'd2);
    checkOutput("postrst_data",    32'(data), 32'h0003);
    checkOutput("postrst_addr",    32'(addr), 32'd2);

    // start held high through a whole MUL with junk operands after the accept.
    wc = writeCount;
    dc = doneCount;
    bus.op    = OP_MUL;
    bus.opa   = 16'h0003;
    bus.opb   = 16'h0005;
    bus.dest  = 3'd5;
    bus.start = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      if (k < 17) begin
        bus.op   = 3'($urandom_range(0, 7));
        bus.opa  = 16'($urandom);
        bus.opb  = 16'($urandom);
        bus.dest = 3'($urandom_range(0, 7));
      end else begin
        bus.start = 1'b0;
      end
    end
    repeat (25) @(negedge clk);
    #2;
    checkOutput("pulsed_write_count", 32'(writeCount - wc), 32'd1);
    checkOutput("pulsed_done_count",  32'(doneCount - dc),  32'd1);
    checkOutput("pulsed_data",        32'(lastData), 32'h000F);
    checkOutput("pulsed_addr",        32'(lastAddr), 32'd5);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/exec_unit_16bit.md
EXEC_UNIT_16BIT -- requirements
Module: exec_unit_16bit

Interface
REQ-001 Parameter WIDTH, 16, datapath width of operands and result.
REQ-002 Parameter ADDR_W, 3, register-bank address width.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset; no other clock or reset exists.
REQ-005 start  input  1  request to execute; accepted only when busy=0.
REQ-006 op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
REQ-007 opa  input  WIDTH  operand A, driven by the register-bank reg_a output.
REQ-008 opb  input  WIDTH  operand B, driven by the register-bank reg_b output.
REQ-009 dest  input  ADDR_W  destination register for the result.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 write  output  1  one-cycle write strobe to the register bank.
REQ-012 write_addr  output  ADDR_W  destination address; valid while write=1.
REQ-013 write_data  output  WIDTH  result; valid while write=1.
REQ-014 done  output  1  one-cycle completion pulse, coincident with write.
REQ-015 flag_z, flag_n, flag_c, flag_v  output  1 each  status flags of the last completed operation.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, MUL and WB; all are registered.
REQ-017 In IDLE with start=1, the block SHALL latch op, opa, opb and dest at the edge, then go to MUL if op=111 and to EXEC otherwise.
REQ-018 start while busy=1 SHALL be ignored, with no queuing, and latched operands SHALL remain unchanged.
REQ-019 EXEC SHALL last exactly one cycle, compute the result into a register, and move to WB.
- Consequence: for ops 000-110, write=1 in the second cycle after the accepting edge.
REQ-020 MUL SHALL perform unsigned shift-add over exactly 16 cycles, one multiplier bit per cycle, LSB first, then move to WB.
- write_data = low 16 bits of the 32-bit product.
- write=1 in the cycle following the 16th MUL cycle.
REQ-021 WB SHALL last exactly one cycle with write=1 and done=1, then return to IDLE.
- A start sampled in WB is ignored.
- The earliest new accept is the first IDLE cycle.
REQ-022 ADD/SUB SHALL wrap modulo 2^16.
- ADD: flag_c = carry out.
- SUB: flag_c = borrow, i.e. 1 when opa < opb unsigned.
- ADD/SUB: flag_v = signed two's-complement overflow.
REQ-023 AND, OR and XOR SHALL clear flag_c and flag_v.
REQ-024 SHL/SHR SHALL shift opa by opb[3:0] and ignore opb[15:4].
- flag_c = last bit shifted out; flag_c = 0 when the shift amount is 0.
- flag_v = 0.
REQ-025 MUL SHALL set flag_c=1 when the upper 16 product bits are non-zero, and set flag_v=0.
REQ-026 flag_z (result==0) and flag_n (result[15]) SHALL be set for every op.
REQ-027 All flags SHALL update only at the edge entering WB and hold until the next WB.
REQ-028 write_addr and write_data SHALL hold their last values outside WB; consumers qualify them with write.

Reset
REQ-029 While reset_n=0, state SHALL be IDLE.
- busy, write, done and all flags = 0.
- write_addr = 0, write_data = 0.
REQ-030 Reset asserted mid-operation (EXEC, MUL or WB) SHALL abort the operation with no write issued after the assertion; the MUL accumulator and counter SHALL clear.
REQ-031 The first start SHALL be accepted on the first rising edge at which reset_n=1 is sampled.

Verification
REQ-032 ADD opa=0x7FFF, opb=0x0001, dest=3 -> write at accept+2, write_data=0x8000, write_addr=3, n=1, v=1, c=0, z=0.
REQ-033 SUB opa=0x0002, opb=0x0003 -> write_data=0xFFFF, c=1, n=1, v=0; SUB 5-5 -> z=1, c=0.
REQ-034 MUL opa=0x0100, opb=0x0100 -> busy for 17 cycles, write_data=0x0000, c=1, z=1; MUL 0xFFFD x 0x0003 -> write_data=0xFFF7, c=1.
REQ-035 SHL opa=0x8001, opb=0xFFF1 (amount 1) -> write_data=0x0002, c=1; SHR by 0 -> result=opa, c=0.
REQ-036 start pulsed every cycle during a MUL -> exactly one write and one done; operands from the ignored starts have no effect.
REQ-037 reset_n dropped in MUL cycle 8 -> busy=0 immediately, no write; after release, ADD 1+2 -> write_data=3 at accept+2.
